// File: rtl/if_fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, runs the single-outstanding IMEM
// request/grant/response handshake and presents instructions to D.
//
// state | meaning
// ------+---------------------------------------------------------------
// REQ   | issuing a fetch at pc (or flagging AdEL when pc is illegal)
// WAIT  | request granted, awaiting its rvalid
// HOLD  | instruction (or AdEL marker) presented to D until accepted
// DROP  | awaiting rvalid of a fetch killed by a redirect
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h00003000,
  parameter logic [31:0] EXC_VEC  = 32'h00004180,
  parameter logic [31:0] PC_LO    = 32'h00003000,
  parameter logic [31:0] PC_HI    = 32'h00006FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        ERET_D,
  input  logic [31:0] EPC_M,
  input  logic        br_take_D,
  input  logic [31:0] br_target_D,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_adel
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic        adel_q;
  logic        outstanding;

  logic        redir;
  logic [31:0] target;
  logic        pc_legal;
  logic        issue;
  logic        rv;

  always_comb begin
    redir  = Req | ERET_D | br_take_D;
    target = br_target_D;
    if (Req)
      target = EXC_VEC;
    else if (ERET_D)
      target = EPC_M;
  end

  assign pc_legal = (pc[1:0] == 2'b00) && (pc >= PC_LO) && (pc <= PC_HI);
  assign issue    = (state == S_REQ) && pc_legal;
  // Responses with no granted request behind them (e.g. from before reset) are dropped.
  assign rv       = imem_rvalid & outstanding;

  assign imem_req  = !reset && issue;
  assign imem_addr = pc;
  assign if_valid  = !reset && (state == S_HOLD);
  assign if_instr  = reset ? 32'h0 : instr_q;
  assign if_pc     = reset ? 32'h0 : pc_q;
  assign if_adel   = !reset && adel_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      instr_q     <= 32'h0;
      pc_q        <= 32'h0;
      adel_q      <= 1'b0;
      outstanding <= 1'b0;
    end else begin
      if (issue && imem_gnt)
        outstanding <= 1'b1;
      else if (rv && ((state == S_WAIT) || (state == S_DROP)))
        outstanding <= 1'b0;

      case (state)
        S_REQ: begin
          if (!pc_legal) begin
            if (redir) begin
              pc <= target;
            end else begin
              state   <= S_HOLD;
              instr_q <= 32'h0;
              pc_q    <= pc;
              adel_q  <= 1'b1;
            end
          end else if (imem_gnt) begin
            state <= redir ? S_DROP : S_WAIT;
            if (redir)
              pc <= target;
          end else if (redir) begin
            pc <= target;
          end
        end
        S_WAIT: begin
          if (rv) begin
            if (redir) begin
              state <= S_REQ;
              pc    <= target;
            end else begin
              state   <= S_HOLD;
              instr_q <= imem_rdata;
              pc_q    <= pc;
              adel_q  <= 1'b0;
            end
          end else if (redir) begin
            state <= S_DROP;
            pc    <= target;
          end
        end
        S_HOLD: begin
          // A transfer coinciding with a redirect still completes; the redirect picks the next pc.
          if (if_ready || redir) begin
            state <= S_REQ;
            pc    <= redir ? target : pc + 32'd4;
          end
        end
        S_DROP: begin
          if (redir)
            pc <= target;
          if (rv)
            state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed vector table followed by randomized traffic
// checked against a transaction-level fetch model.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Req = 1'b0;
  logic        ERET_D = 1'b0;
  logic [31:0] EPC_M = 32'h0;
  logic        br_take_D = 1'b0;
  logic [31:0] br_target_D = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_adel;

  if_fetch_ctrl dut (
    .clk(clk), .reset(reset), .Req(Req), .ERET_D(ERET_D), .EPC_M(EPC_M),
    .br_take_D(br_take_D), .br_target_D(br_target_D),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .if_adel(if_adel)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst, gnt, rv;
    logic [31:0] rdata;
    logic        rdy, exc, eret;
    logic [31:0] epc;
    logic        br;
    logic [31:0] brt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc, e_instr;
    logic        e_adel;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        adel;
  } hold_t;

  vec_t  vecs[$];
  hold_t m_hold[$];
  logic [31:0] m_pc;
  bit    m_inflight;
  bit    m_stale;
  int    lat;

  task automatic add(input logic rst, gnt, rv, input logic [31:0] rdata,
                     input logic rdy, exc, eret, input logic [31:0] epc,
                     input logic br, input logic [31:0] brt,
                     input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                     input logic [31:0] e_pc, e_instr, input logic e_adel);
    vec_t v;
    v.rst = rst; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.rdy = rdy;
    v.exc = exc; v.eret = eret; v.epc = epc; v.br = br; v.brt = brt;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_adel = e_adel;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                            input logic [31:0] e_pc, e_instr, input logic e_adel,
                            input logic check_data);
    chk("imem_req", 32'(imem_req), 32'(e_req));
    if (e_req)
      chk("imem_addr", imem_addr, e_addr);
    chk("if_valid", 32'(if_valid), 32'(e_valid));
    if (check_data) begin
      chk("if_pc", if_pc, e_pc);
      chk("if_instr", if_instr, e_instr);
      chk("if_adel", 32'(if_adel), 32'(e_adel));
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a >= 32'h00003000) && (a <= 32'h00006FFC);
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = 32'h00003000 + (32'($urandom_range(0, 32'hFFF)) << 2);
    case ($urandom % 10)
      0: t = 32'h00007000;
      1: t = 32'h00002FFC;
      2: t = t + 32'd2;
      default: ;
    endcase
    return t;
  endfunction

  // Fetch model: PC advances per accepted instruction, redirects kill whatever
  // is pending, an in-flight response after a redirect is thrown away.
  task automatic model_update();
    logic        redir;
    logic [31:0] tgt;
    hold_t       h;
    redir = Req | ERET_D | br_take_D;
    tgt   = Req ? 32'h00004180 : (ERET_D ? EPC_M : br_target_D);
    if (m_hold.size() != 0) begin
      if (if_ready || redir)
        void'(m_hold.pop_front());
      if (redir)
        m_pc = tgt;
      else if (if_ready)
        m_pc = m_pc + 32'd4;
    end else if (m_inflight) begin
      if (imem_rvalid) begin
        m_inflight = 0;
        if (!m_stale && !redir) begin
          h.instr = imem_rdata; h.pc = m_pc; h.adel = 1'b0;
          m_hold.push_back(h);
        end
        m_stale = 0;
      end else begin
        lat--;
        if (redir)
          m_stale = 1;
      end
      if (redir)
        m_pc = tgt;
    end else if (!legal(m_pc)) begin
      if (redir) begin
        m_pc = tgt;
      end else begin
        h.instr = 32'h0; h.pc = m_pc; h.adel = 1'b1;
        m_hold.push_back(h);
      end
    end else begin
      if (imem_gnt) begin
        m_inflight = 1;
        m_stale    = redir;
        lat        = int'($urandom_range(0, 2));
      end
      if (redir)
        m_pc = tgt;
    end
  endtask

  initial begin
    logic [31:0] A, B, C;
    A = 32'h11110001; B = 32'h22220002; C = 32'h33330003;

    add(1,0,0,0,0,0,0,0,0,0,            0,0,0,0,0,0);
    add(1,0,0,0,0,0,0,0,0,0,            0,0,0,0,0,0);
    add(0,1,0,0,0,0,0,0,0,0,            1,32'h3000,0,0,0,0);
    add(0,0,1,A,0,0,0,0,0,0,            0,0,0,0,0,0);
    add(0,0,0,0,1,0,0,0,0,0,            0,0,1,32'h3000,A,0);
    add(0,1,0,0,0,0,0,0,0,0,            1,32'h3004,0,0,0,0);
    add(0,0,1,B,0,0,0,0,0,0,            0,0,0,0,0,0);
    for (int k = 0; k < 5; k++)
      add(0,0,0,0,0,0,0,0,0,0,          0,0,1,32'h3004,B,0);
    add(0,0,0,0,1,0,0,0,0,0,            0,0,1,32'h3004,B,0);
    add(0,0,0,0,0,0,0,0,0,0,            1,32'h3008,0,0,0,0);
    add(0,1,0,0,0,0,0,0,0,0,            1,32'h3008,0,0,0,0);
    add(0,0,0,0,0,0,0,0,1,32'h3100,     0,0,0,0,0,0);
    add(0,0,0,0,0,0,0,0,0,0,            0,0,0,0,0,0);
    add(0,0,0,0,0,0,0,0,0,0,            0,0,0,0,0,0);
    add(0,0,1,32'hDEADBEEF,0,0,0,0,0,0, 0,0,0,0,0,0);
    add(0,0,0,0,0,0,0,0,0,0,            1,32'h3100,0,0,0,0);
    add(0,0,0,0,0,1,0,0,1,32'h3200,     1,32'h3100,0,0,0,0);
    add(0,0,0,0,0,0,1,32'h3208,0,0,     1,32'h4180,0,0,0,0);
    add(0,0,0,0,0,0,0,0,1,32'h3002,     1,32'h3208,0,0,0,0);
    add(0,0,0,0,0,0,0,0,0,0,            0,0,0,0,0,0);
    add(0,0,0,0,0,0,0,0,1,32'h7000,     0,0,1,32'h3002,0,1);
    add(0,0,0,0,0,0,0,0,0,0,            0,0,0,0,0,0);
    add(0,0,0,0,1,0,0,0,1,32'h3300,     0,0,1,32'h7000,0,1);
    add(0,1,0,0,0,0,0,0,0,0,            1,32'h3300,0,0,0,0);
    add(1,0,0,0,0,0,0,0,0,0,            0,0,0,0,0,0);
    add(0,0,1,32'hBAD00BAD,0,0,0,0,0,0, 1,32'h3000,0,0,0,0);
    add(0,1,0,0,0,0,0,0,0,0,            1,32'h3000,0,0,0,0);
    add(0,0,1,C,0,0,0,0,0,0,            0,0,0,0,0,0);
    add(0,0,0,0,1,0,0,0,0,0,            0,0,1,32'h3000,C,0);
    add(0,0,0,0,0,0,0,0,0,0,            1,32'h3004,0,0,0,0);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; imem_gnt = vecs[i].gnt; imem_rvalid = vecs[i].rv;
      imem_rdata = vecs[i].rdata; if_ready = vecs[i].rdy; Req = vecs[i].exc;
      ERET_D = vecs[i].eret; EPC_M = vecs[i].epc; br_take_D = vecs[i].br;
      br_target_D = vecs[i].brt;
      #2;
      check_outs(vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_pc,
                 vecs[i].e_instr, vecs[i].e_adel, vecs[i].e_valid | vecs[i].rst);
      @(posedge clk);
      #1;
    end

    reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; if_ready = 1'b0;
    Req = 1'b0; ERET_D = 1'b0; br_take_D = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_pc = 32'h00003000; m_inflight = 0; m_stale = 0; lat = 0;
    m_hold.delete();

    for (int n = 0; n < 3000; n++) begin
      imem_rvalid = m_inflight && (lat == 0);
      imem_rdata  = $urandom;
      imem_gnt    = ($urandom % 3) != 0;
      if_ready    = ($urandom % 4) != 0;
      Req         = ($urandom % 40) == 0;
      ERET_D      = ($urandom % 30) == 0;
      EPC_M       = rand_target();
      br_take_D   = ($urandom % 15) == 0;
      br_target_D = rand_target();
      #1;
      if (m_hold.size() != 0)
        check_outs(1'b0, 32'h0, 1'b1, m_hold[0].pc, m_hold[0].instr, m_hold[0].adel, 1'b1);
      else
        check_outs(!m_inflight && legal(m_pc), m_pc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      model_update();
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
